ex_result_buffer: RTL and testbench

Output-side stage placed directly downstream of the CORDIC execution top. The execution pipeline has no stall input, so this block captures every result beat it emits into a first-word-fall-through FIFO. It presents the results to the consumer over a valid/ready handshake, and returns an issue credit to the upstream issuer so results are never dropped under backpressure.

---
 rtl/ex_result_buffer.sv | 141 ++++++++++++++
 tb/tb_ex_result_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_result_buffer.sv
// ex_result_buffer
//   Captures every result beat from the CORDIC execution stage (which cannot
//   stall) into a first-word-fall-through FIFO. The FIFO head is presented to
//   the consumer over valid/ready. Issue credits go back to the issuer so that
//   beats already in flight always have a free slot waiting for them.
//
// Ports
//   clk, reset                 clock (rising edge), async active-low reset
//   issue_fire / issue_ready   issuer handshake (credit based)
//   valid_out_interface, arctan_en_out_interface, degree/x/y_out_interface
//                              result beat from the execution stage
//   res_valid / res_ready      consumer handshake; res_* is the FIFO head
//   occupancy                  stored entries, 0..DEPTH
//   overflow                   sticky: beat dropped or credit underflow
//   result_count, drop_count   statistics (see below)
//
// Build option
//   EX_RESULT_BUF_STATS_EN  when defined, result_count (wrapping) and
//                           drop_count (saturating) are built; otherwise both
//                           ports read 0 and no counter flops exist.
module ex_result_buffer #(
  parameter int OUTPUT_WIDTH = 16,
  parameter int DEPTH        = 8,
  parameter int PTR_WIDTH    = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           issue_fire,
  output logic                           issue_ready,
  input  logic                           valid_out_interface,
  input  logic                           arctan_en_out_interface,
  input  logic signed [OUTPUT_WIDTH-1:0] degree_out_interface,
  input  logic signed [OUTPUT_WIDTH-1:0] x_out_interface,
  input  logic signed [OUTPUT_WIDTH-1:0] y_out_interface,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic                           res_arctan_en,
  output logic signed [OUTPUT_WIDTH-1:0] res_degree,
  output logic signed [OUTPUT_WIDTH-1:0] res_x,
  output logic signed [OUTPUT_WIDTH-1:0] res_y,
  output logic [PTR_WIDTH:0]             occupancy,
  output logic                           overflow,
  output logic [31:0]                    result_count,
  output logic [15:0]                    drop_count
);

  typedef struct packed {
    logic                    arctan_en;
    logic [OUTPUT_WIDTH-1:0] degree;
    logic [OUTPUT_WIDTH-1:0] x;
    logic [OUTPUT_WIDTH-1:0] y;
  } entry_t;

  localparam logic [PTR_WIDTH:0]   FULL_CNT = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]   CNT_ONE  = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH+1:0] CREDITS  = (PTR_WIDTH+2)'(DEPTH);

  entry_t                 mem [DEPTH];
  entry_t                 head;
  logic [PTR_WIDTH-1:0]   wr_ptr, rd_ptr;
  logic [PTR_WIDTH:0]     occ, inflight;
  logic [PTR_WIDTH+1:0]   credit_sum;
  logic                   push, pop, full, wr_en, drop;

  assign push  = valid_out_interface;
  assign pop   = res_valid & res_ready;
  assign full  = (occ == FULL_CNT);
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  // Credits cover both stored entries and beats still inside the execution
  // stage; only registered state feeds this, so issuers see no comb path.
  assign credit_sum  = {1'b0, occ} + {1'b0, inflight};
  assign issue_ready = (credit_sum < CREDITS);

  assign head          = mem[rd_ptr];
  assign res_valid     = (occ != '0);
  assign res_arctan_en = head.arctan_en;
  assign res_degree    = head.degree;
  assign res_x         = head.x;
  assign res_y         = head.y;
  assign occupancy     = occ;

  // Storage is intentionally not reset; contents are only observed once
  // written and res_valid is high.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {arctan_en_out_interface, degree_out_interface,
                      x_out_interface, y_out_interface};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      inflight <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   occ <= occ + CNT_ONE;
        2'b01:   occ <= occ - CNT_ONE;
        default: ;
      endcase
      // A beat arriving with nothing in flight is a credit underflow; the
      // counter holds at zero rather than wrapping.
      if (issue_fire && !push)
        inflight <= inflight + CNT_ONE;
      else if (push && !issue_fire && inflight != '0)
        inflight <= inflight - CNT_ONE;
      if (drop || (push && inflight == '0))
        overflow <= 1'b1;
    end
  end

`ifdef EX_RESULT_BUF_STATS_EN
  logic [31:0] res_cnt;
  logic [15:0] drp_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_cnt <= '0;
      drp_cnt <= '0;
    end else begin
      if (pop) res_cnt <= res_cnt + 32'd1;
      if (drop && drp_cnt != 16'hFFFF) drp_cnt <= drp_cnt + 16'd1;
    end
  end

  assign result_count = res_cnt;
  assign drop_count   = drp_cnt;
`else
  assign result_count = '0;
  assign drop_count   = '0;
`endif

endmodule

// File: tb/tb_ex_result_buffer.sv
// Bench for ex_result_buffer: a small delay-line stands in for the execution
// stage; a queue-based model predicts FIFO contents, credits and stats.
module tb_ex_result_buffer;
  localparam int W   = 16;
  localparam int D   = 8;
  localparam int PW  = 3;
  localparam int LAT = 2;
  localparam int EW  = 3*W+1;

  logic                gclk;
  logic                reset;
  logic                issue_fire, issue_ready;
  logic                valid_out_interface, arctan_en_out_interface;
  logic signed [W-1:0] degree_out_interface, x_out_interface, y_out_interface;
  logic                res_valid, res_ready, res_arctan_en;
  logic signed [W-1:0] res_degree, res_x, res_y;
  logic [PW:0]         occupancy;
  logic                overflow;
  logic [31:0]         result_count;
  logic [15:0]         drop_count;

  ex_result_buffer #(.OUTPUT_WIDTH(W), .DEPTH(D), .PTR_WIDTH(PW)) dut (
    .clk(gclk), .reset(reset),
    .issue_fire(issue_fire), .issue_ready(issue_ready),
    .valid_out_interface(valid_out_interface),
    .arctan_en_out_interface(arctan_en_out_interface),
    .degree_out_interface(degree_out_interface),
    .x_out_interface(x_out_interface), .y_out_interface(y_out_interface),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_arctan_en(res_arctan_en), .res_degree(res_degree),
    .res_x(res_x), .res_y(res_y),
    .occupancy(occupancy), .overflow(overflow),
    .result_count(result_count), .drop_count(drop_count)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  int checks   = 0;
  int failures = 0;

  // reference model
  logic [EW-1:0] q[$];
  int            infl;
  bit            m_ovf;
  int unsigned   m_rc;
  int            m_dc;
  // execution-stage stand-in
  logic          pv [LAT];
  logic [EW-1:0] pd [LAT];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    chk("res_valid", res_valid, q.size() != 0);
    chk("occupancy", occupancy, q.size());
    chk("issue_ready", issue_ready, (q.size() + infl) < D);
    chk("overflow", overflow, m_ovf);
`ifdef EX_RESULT_BUF_STATS_EN
    chk("result_count", result_count, m_rc);
    chk("drop_count", drop_count, m_dc);
`else
    chk("result_count", result_count, 0);
    chk("drop_count", drop_count, 0);
`endif
    if (q.size() != 0)
      chk("head", {res_arctan_en, res_degree, res_x, res_y}, q[0]);
  endtask

  function automatic logic [EW-1:0] rnd_e();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[EW-1:0];
  endfunction

  function automatic bit credit_ok();
    return (q.size() + infl) < D;
  endfunction

  // Drive one cycle of inputs, advance the model, clock, then check.
  task automatic tick(input bit iss, input bit rr, input logic [EW-1:0] e);
    bit            full, pop, push;
    logic [EW-1:0] beat;
    issue_fire          = iss;
    res_ready           = rr;
    push                = pv[LAT-1];
    beat                = pd[LAT-1];
    valid_out_interface = push;
    {arctan_en_out_interface, degree_out_interface, x_out_interface, y_out_interface} = beat;
    for (int i = LAT-1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = iss;
    pd[0] = e;
    if (!reset) begin
      q.delete(); infl = 0; m_ovf = 0; m_rc = 0; m_dc = 0;
    end else begin
      full = (q.size() == D);
      pop  = (q.size() != 0) && rr;
      if (pop) begin
        void'(q.pop_front());
        m_rc++;
      end
      if (push) begin
        if (!full || pop) q.push_back(beat);
        else begin
          m_ovf = 1;
          if (m_dc < 65535) m_dc++;
        end
        if (infl == 0) m_ovf = 1;
      end
      if (iss && !push) infl++;
      else if (push && !iss && infl > 0) infl--;
    end
    @(posedge gclk);
    @(negedge gclk);
    check_all();
  endtask

  initial begin
    int n;
    int issued;
    bit c;
    for (int i = 0; i < LAT; i++) begin pv[i] = 0; pd[i] = '0; end
    q.delete(); infl = 0; m_ovf = 0; m_rc = 0; m_dc = 0;
    issue_fire = 0; res_ready = 0; valid_out_interface = 0;
    {arctan_en_out_interface, degree_out_interface, x_out_interface, y_out_interface} = '0;
    reset = 1'b0;
    #2;

    // reset with random activity, then let the stand-in pipe flush
    for (int i = 0; i < 5; i++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_e());
    for (int i = 0; i < LAT; i++) tick(0, 0, '0);
    chk("reset_issue_ready", issue_ready, 1'b1);
    reset = 1'b1;

    // single beat
    tick(1, 1, {1'b0, 16'h0100, 16'h009B, 16'h0000});
    for (int i = 0; i < LAT; i++) tick(0, 1, '0);
    chk("single_valid", res_valid, 1'b1);
    chk("single_deg", res_degree, 16'h0100);
    chk("single_x", res_x, 16'h009B);
    chk("single_y", res_y, 16'h0000);
    tick(0, 1, '0);
    chk("single_empty", occupancy, 0);
    chk("single_credit", issue_ready, 1'b1);

    // credit backpressure: exactly DEPTH issues fit
    n = 0;
    for (int i = 0; i < 16; i++) begin
      c = credit_ok();
      tick(c, 0, rnd_e());
      n += int'(c);
    end
    chk("bp_issues", n, D);
    chk("bp_occ", occupancy, D);
    chk("bp_ready_low", issue_ready, 1'b0);
    chk("bp_no_ovf", overflow, 1'b0);
    for (int i = 0; i < D + 1; i++) tick(0, 1, rnd_e());
    chk("bp_ready_back", issue_ready, 1'b1);

    // full with simultaneous push/pop across pointer wrap
    for (int i = 0; i < 16; i++) tick(credit_ok(), 0, rnd_e());
    tick(1, 0, rnd_e());
    tick(1, 0, rnd_e());
    tick(1, 1, rnd_e());
    chk("full_pp_occ0", occupancy, D);
    tick(0, 1, '0);
    tick(0, 1, '0);
    chk("full_pp_occ", occupancy, D);
    chk("full_pp_no_ovf", overflow, 1'b0);

    // forced drop
    tick(1, 0, rnd_e());
    tick(0, 0, '0);
    tick(0, 0, '0);
    chk("drop_ovf", overflow, 1'b1);
`ifdef EX_RESULT_BUF_STATS_EN
    chk("drop_cnt", drop_count, 16'd1);
`endif
    for (int i = 0; i < D + 1; i++) tick(0, 1, '0);
    chk("drop_drained", res_valid, 1'b0);

    // stats: 20 delivered results after a fresh reset
    reset = 1'b0;
    tick(0, 0, '0);
    reset = 1'b1;
    issued = 0;
    for (int i = 0; i < 40; i++) begin
      c = credit_ok() && issued < 20;
      tick(c, 1, rnd_e());
      issued += int'(c);
    end
`ifdef EX_RESULT_BUF_STATS_EN
    chk("stats_20", result_count, 32'd20);
`else
    chk("stats_off", result_count, 32'd0);
`endif

    // random traffic, occasional protocol violations
    for (int i = 0; i < 300; i++) begin
      c = ($urandom_range(0, 19) == 0) ? 1'b1 : credit_ok();
      tick(c && ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rnd_e());
    end

    // reset while beats are still inside the execution stage
    tick(1, 0, rnd_e());
    reset = 1'b0;
    tick(1, 0, rnd_e());
    reset = 1'b1;
    for (int i = 0; i < 30; i++)
      tick(credit_ok() && ($urandom_range(0, 1) != 0), 1'($urandom_range(0, 1)), rnd_e());
    chk("post_reset_ovf", overflow, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
